mult_div_unit: RTL



---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mult_div_unit_if.sv | 29 ++
 rtl/mdu_abs.sv | 13 +
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and sizing for the HI/LO multiply/divide unit.
// Optional early-exit behaviour is selected by the MDU_EARLY_OUT_EN macro.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int ITER      = MDU_WIDTH;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX
    } state_e;

    function automatic int cnt_width(input int iter);
        return $clog2(iter + 1);
    endfunction

    localparam int CNT_W = cnt_width(ITER);

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand, MTHI/MTLO and HI/LO result bundle between control and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = mdu_pkg::MDU_WIDTH
);
    import mdu_pkg::*;

    logic             start;
    op_e              op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_abs.sv
// Conditional two's-complement negate: result = neg ? -value : value.
// Used both to take operand magnitudes and to re-apply result signs.
module mdu_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: IDLE -> PREP -> CALC (ITER steps) -> FIX.
// Define MDU_EARLY_OUT_EN to let multiplies and divide-by-zero finish early.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input logic            clk,
    input logic            rst,
    mult_div_unit_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam int W2 = 2 * WIDTH;

    state_e           state, state_next;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] opnd_q;     // multiplicand or divisor magnitude
    logic [W2-1:0]    acc_q;      // {partial product, multiplier} or {remainder, quotient}
    logic [CW-1:0]    cnt_q;
    logic             sign_q, sign_r, div0_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             is_div, is_signed, div0_now, busy;
    logic [WIDTH-1:0] mag_a, mag_b, quot_fix, rem_fix;
    logic [W2-1:0]    acc_step, acc_fix, prod_fix;
    logic [WIDTH:0]   mul_sum, div_trial, div_diff;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign div0_now  = is_div && (b_q == '0);

    mdu_abs #(.WIDTH(WIDTH)) u_abs_a (.value(a_q), .neg(is_signed & a_q[WIDTH-1]), .result(mag_a));
    mdu_abs #(.WIDTH(WIDTH)) u_abs_b (.value(b_q), .neg(is_signed & b_q[WIDTH-1]), .result(mag_b));
    mdu_abs #(.WIDTH(W2))    u_neg_p (.value(acc_fix), .neg(sign_q), .result(prod_fix));
    mdu_abs #(.WIDTH(WIDTH)) u_neg_q (.value(acc_fix[WIDTH-1:0]), .neg(sign_q), .result(quot_fix));
    mdu_abs #(.WIDTH(WIDTH)) u_neg_r (.value(acc_fix[W2-1:WIDTH]), .neg(sign_r), .result(rem_fix));

    // One shift-add multiply step or one restoring-divide step.
    always_comb begin
        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = acc_q[W2-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opnd_q};
        if (!is_div)
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

`ifdef MDU_EARLY_OUT_EN
    logic [CW-1:0]    cnt_inc, shamt;
    logic [WIDTH-1:0] rest_mask;
    logic             rest_zero;

    // Unconsumed multiplier bits sit below the product bits shifted in so far.
    assign cnt_inc   = cnt_q + CW'(1);
    assign rest_mask = {WIDTH{1'b1}} >> cnt_inc;
    assign rest_zero = (acc_step[WIDTH-1:0] & rest_mask) == '0;
    assign shamt     = CW'(WIDTH) - cnt_q;
    assign acc_fix   = acc_q >> shamt;
`else
    assign acc_fix   = acc_q;
`endif

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        unique case (state)
            S_IDLE: if (bus.start) state_next = S_PREP;
`ifdef MDU_EARLY_OUT_EN
            S_PREP: state_next = (div0_now || (!is_div && mag_b == '0)) ? S_FIX : S_CALC;
            S_CALC: if (cnt_q == CW'(WIDTH - 1) || (!is_div && rest_zero)) state_next = S_FIX;
`else
            S_PREP: state_next = S_CALC;
            S_CALC: if (cnt_q == CW'(WIDTH - 1)) state_next = S_FIX;
`endif
            S_FIX:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_MULT;
            a_q    <= '0;
            b_q    <= '0;
            opnd_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            div0_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        a_q  <= bus.rs_data;
                        b_q  <= bus.rt_data;
                    end
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                end
                S_PREP: begin
                    sign_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    sign_r <= is_signed & a_q[WIDTH-1];
                    div0_q <= div0_now;
                    opnd_q <= is_div ? mag_b : mag_a;
                    acc_q  <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    cnt_q  <= '0;
                end
                S_CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_FIX: begin
                    done_q <= 1'b1;
                    cnt_q  <= '0;
                    if (div0_q) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end else if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
